// File: rtl/lenet_hls_mul_pkg.sv
// Shared widths and round-robin pick helper for the LeNet HLS shared-multiplier arbiter.
package lenet_hls_mul_pkg;

  localparam int MUL_A_W = 25;
  localparam int MUL_B_W = 25;
  localparam int MUL_P_W = 50;
  localparam int MAX_REQ = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of valid, scanning from ptr upward and wrapping modulo n_req.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [2:0]         ptr,
                                       input int                 n_req);
    rr_pick_t res;
    int       j;
    res = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      j = (int'(ptr) + i) % n_req;
      if ((i < n_req) && !res.found && valid[j]) begin
        res.found = 1'b1;
        res.idx   = 3'(j);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/lenet_hls_mul_25ns_25ns_50_1_1.sv
// Shared combinational unsigned multiplier (25 x 25 -> 50).
module lenet_hls_mul_25ns_25ns_50_1_1 #(
  parameter int din0_WIDTH = 25,
  parameter int din1_WIDTH = 25,
  parameter int dout_WIDTH = 50
) (
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);

  // Operands widened first so the product is computed at full output width.
  assign dout = {{(dout_WIDTH-din0_WIDTH){1'b0}}, din0} *
                {{(dout_WIDTH-din1_WIDTH){1'b0}}, din1};

endmodule

// File: rtl/lenet_hls_mul_arbiter.sv
// Round-robin arbiter feeding one shared 25x25 multiplier through a two-stage
// operand/result pipeline, with a delivered-product counter.
module lenet_hls_mul_arbiter
  import lenet_hls_mul_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*MUL_A_W-1:0]   req_a,
  input  logic [N_REQ*MUL_B_W-1:0]   req_b,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [MUL_P_W-1:0]         res_data,
  output logic [ID_W-1:0]            res_id,
  output logic                       busy,
  output logic [31:0]                prod_count
);

  logic               s1_valid_q, s1_valid_d;
  logic [MUL_A_W-1:0] s1_a_q, s1_a_d;
  logic [MUL_B_W-1:0] s1_b_q, s1_b_d;
  logic [ID_W-1:0]    s1_id_q, s1_id_d;
  logic               res_valid_q, res_valid_d;
  logic [MUL_P_W-1:0] res_data_q, res_data_d;
  logic [ID_W-1:0]    res_id_q, res_id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [31:0]        prod_count_q, prod_count_d;

  logic [MAX_REQ-1:0] valid_ext_s;
  rr_pick_t           pick_s;
  logic [ID_W-1:0]    winner_s;
  logic               s2_adv_s, s1_adv_s, accept_s, res_hs_s;
  logic [MUL_P_W-1:0] mul_p_s;

  lenet_hls_mul_25ns_25ns_50_1_1 #(
    .din0_WIDTH(MUL_A_W),
    .din1_WIDTH(MUL_B_W),
    .dout_WIDTH(MUL_P_W)
  ) u_mul (
    .din0(s1_a_q),
    .din1(s1_b_q),
    .dout(mul_p_s)
  );

  always_comb begin
    valid_ext_s              = '0;
    valid_ext_s[N_REQ-1:0]   = req_valid;
    pick_s                   = rr_pick(valid_ext_s, 3'(rr_ptr_q), N_REQ);
    winner_s                 = ID_W'(pick_s.idx);
    s2_adv_s                 = !res_valid_q || res_ready;
    s1_adv_s                 = !s1_valid_q || s2_adv_s;
    accept_s                 = pick_s.found && s1_adv_s && !ap_rst;
    res_hs_s                 = res_valid_q && res_ready;
    req_ready                = '0;
    if (accept_s) begin
      req_ready[winner_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Next state: a new load, S1->S2 transfer and S2 drain may all coincide.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_id_d      = s1_id_q;
    rr_ptr_d     = rr_ptr_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_id_d     = res_id_q;
    prod_count_d = res_hs_s ? prod_count_q + 32'd1 : prod_count_q;

    if (accept_s) begin
      s1_valid_d = 1'b1;
      s1_a_d     = req_a[winner_s*MUL_A_W +: MUL_A_W];
      s1_b_d     = req_b[winner_s*MUL_B_W +: MUL_B_W];
      s1_id_d    = winner_s;
      rr_ptr_d   = (winner_s == ID_W'(N_REQ-1)) ? '0 : winner_s + ID_W'(1);
    end else if (s1_adv_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s2_adv_s) begin
      res_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_data_d = mul_p_s;
        res_id_d   = s1_id_q;
      end else begin
        res_data_d = res_data_q;
      end
    end else begin
      res_valid_d = res_valid_q;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_id_q      <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_id_q     <= '0;
      rr_ptr_q     <= '0;
      prod_count_q <= 32'd0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_id_q      <= s1_id_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_id_q     <= res_id_d;
      rr_ptr_q     <= rr_ptr_d;
      prod_count_q <= prod_count_d;
    end
  end

  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_id     = res_id_q;
  assign busy       = s1_valid_q || res_valid_q;
  assign prod_count = prod_count_q;

endmodule

// File: tb/tb_lenet_hls_mul_arbiter.sv
// Directed bench for lenet_hls_mul_arbiter (N_REQ=4): product table, fairness,
// backpressure, mid-flight reset and counter wrap.
module tb_lenet_hls_mul_arbiter;

  logic         ap_clk = 1'b0;
  logic         ap_rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [99:0]  req_a;
  logic [99:0]  req_b;
  logic         res_valid;
  logic         res_ready;
  logic [49:0]  res_data;
  logic [1:0]   res_id;
  logic         busy;
  logic [31:0]  prod_count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          id;
    logic [24:0] a;
    logic [24:0] b;
    logic [49:0] p;
  } vec_t;

  vec_t vecs[7];

  lenet_hls_mul_arbiter #(.N_REQ(4)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy),
    .prod_count(prod_count)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [24:0] a, input logic [24:0] b);
    req_a[i*25 +: 25] = a;
    req_b[i*25 +: 25] = b;
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst    = 1'b1;
    req_valid = 4'h0;
    @(negedge ap_clk);
    ap_rst    = 1'b0;
  endtask

  initial begin
    int acc;
    int got;

    vecs[0] = '{2, 25'd3,         25'd5,         50'd15};
    vecs[1] = '{0, 25'h1FFFFFF,   25'h1FFFFFF,   50'h3FFFFFC000001};
    vecs[2] = '{1, 25'd0,         25'd12345,     50'd0};
    vecs[3] = '{3, 25'd1,         25'h1FFFFFF,   50'h1FFFFFF};
    vecs[4] = '{2, 25'd1000,      25'd1000,      50'd1000000};
    vecs[5] = '{1, 25'h1000000,   25'd2,         50'h2000000};
    vecs[6] = '{3, 25'h1FFFFFF,   25'd2,         50'h3FFFFFE};

    ap_rst    = 1'b1;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;

    @(negedge ap_clk);
    #1;
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_prod_count", 64'(prod_count), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_res_id", 64'(res_id), 64'd0);
    @(negedge ap_clk);
    ap_rst    = 1'b0;
    req_valid = 4'h0;

    // Isolated single-requester products: ready same cycle, result two cycles later.
    for (int k = 0; k < 7; k++) begin
      @(negedge ap_clk);
      set_lane(vecs[k].id, vecs[k].a, vecs[k].b);
      req_valid = 4'(1 << vecs[k].id);
      #1;
      check("vec_req_ready", 64'(req_ready), 64'(1 << vecs[k].id));
      @(negedge ap_clk);
      req_valid = 4'h0;
      #1;
      check("vec_res_valid_c1", 64'(res_valid), 64'd0);
      check("vec_busy_c1", 64'(busy), 64'd1);
      @(negedge ap_clk);
      #1;
      check("vec_res_valid_c2", 64'(res_valid), 64'd1);
      check("vec_res_data", 64'(res_data), 64'(vecs[k].p));
      check("vec_res_id", 64'(res_id), 64'(vecs[k].id));
      @(negedge ap_clk);
      #1;
      check("vec_prod_count", 64'(prod_count), 64'(k + 1));
      check("vec_res_drained", 64'(res_valid), 64'd0);
    end

    // Fairness and full throughput with every requester valid.
    do_reset();
    for (int i = 0; i < 4; i++) set_lane(i, 25'(i + 1), 25'd10);
    res_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge ap_clk);
      req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      check("rr_req_ready", 64'(req_ready), (k < 8) ? 64'(1 << (k % 4)) : 64'd0);
      if (k >= 2) begin
        check("rr_res_valid", 64'(res_valid), 64'd1);
        check("rr_res_id", 64'(res_id), 64'((k - 2) % 4));
        check("rr_res_data", 64'(res_data), 64'((((k - 2) % 4) + 1) * 10));
      end else begin
        check("rr_res_valid_early", 64'(res_valid), 64'd0);
      end
    end
    @(negedge ap_clk);
    #1;
    check("rr_prod_count", 64'(prod_count), 64'd8);

    // Backpressure: only S2 and S1 fill, then ready stays low.
    do_reset();
    for (int i = 0; i < 4; i++) set_lane(i, 25'(i + 1), 25'd7);
    res_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge ap_clk);
      req_valid = 4'hF;
      #1;
      if (req_ready != 4'h0) acc++;
      if (k >= 2) check("bp_ready_low", 64'(req_ready), 64'd0);
    end
    check("bp_accepts", 64'(acc), 64'd2);
    @(negedge ap_clk);
    req_valid = 4'h0;
    res_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (res_valid) begin
        check("bp_res_id", 64'(res_id), 64'(got));
        check("bp_res_data", 64'(res_data), 64'((got + 1) * 7));
        got++;
      end
      @(negedge ap_clk);
    end
    check("bp_results", 64'(got), 64'd2);
    check("bp_prod_count", 64'(prod_count), 64'd2);

    // Mid-flight reset with both stages full and rr_ptr away from zero.
    res_ready = 1'b0;
    req_valid = 4'b0110;
    #1;
    check("mf_grant_a", 64'(req_ready), 64'b0100);
    @(negedge ap_clk);
    #1;
    check("mf_grant_b", 64'(req_ready), 64'b0010);
    @(negedge ap_clk);
    #1;
    check("mf_full_busy", 64'(busy), 64'd1);
    check("mf_full_res_valid", 64'(res_valid), 64'd1);
    ap_rst    = 1'b1;
    req_valid = 4'hF;
    #1;
    check("mf_ready_in_rst", 64'(req_ready), 64'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    #1;
    check("mf_res_valid", 64'(res_valid), 64'd0);
    check("mf_busy", 64'(busy), 64'd0);
    check("mf_prod_count", 64'(prod_count), 64'd0);
    check("mf_ptr_zero", 64'(req_ready), 64'b0001);
    req_valid = 4'h0;
    res_ready = 1'b1;
    @(negedge ap_clk);
    #1;
    check("mf_no_ghost", 64'(res_valid), 64'd0);

    // Counter wrap from all-ones.
    force dut.prod_count_q = 32'hFFFFFFFF;
    @(negedge ap_clk);
    release dut.prod_count_q;
    #1;
    check("wrap_preset", 64'(prod_count), 64'hFFFFFFFF);
    set_lane(0, 25'd6, 25'd7);
    req_valid = 4'b0001;
    @(negedge ap_clk);
    req_valid = 4'h0;
    @(negedge ap_clk);
    #1;
    check("wrap_res_data", 64'(res_data), 64'd42);
    @(negedge ap_clk);
    #1;
    check("wrap_prod_count", 64'(prod_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
